i2c_ov7670_config: RTL and testbench

//  Register-initialisation sequencer for the OV7670 SCCB port. Directly upstream of the I2C byte-transfer controller.

---
 rtl/i2c_ov7670_config.sv | 176 +++++++++++++++++
 tb/tb_i2c_ov7670_config.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_ov7670_config.sv
// OV7670 SCCB register-init sequencer: free-running bit-clock divider, LUT walker, one go/end write per entry with NACK retry.
// Optional CFG_RESTART_EN lets a cfg_restart pulse in S_DONE rerun the table without the power-up delay.
module i2c_ov7670_config #(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned I2C_FREQ       = 100_000,
  parameter int unsigned LUT_SIZE       = 168,
  parameter int unsigned INIT_DELAY_CYC = 1_000_000,
  parameter logic [7:0]  SLAVE_ADDR     = 8'h42,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  output logic        i2c_clk,
  output logic        i2c_en,
  output logic [23:0] i2c_wdata,
  output logic        i2c_wr,
  output logic        i2c_go,
  input  logic        i2c_end,
  input  logic        i2c_ack,
  output logic [7:0]  lut_index,
  input  logic [15:0] lut_data,
  output logic        cfg_done,
  output logic        cfg_err,
  input  logic        cfg_restart
);

  localparam int unsigned DIV = CLK_FREQ / I2C_FREQ;
  localparam int unsigned DCW = $clog2(DIV);
  localparam int unsigned DLW = (INIT_DELAY_CYC > 1) ? $clog2(INIT_DELAY_CYC) : 1;
  localparam int unsigned RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_DELAY, S_LOAD, S_GO, S_CHECK, S_GAP, S_NEXT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [DCW-1:0]  div_cnt_q, div_cnt_d;
  logic            i2c_clk_q, i2c_clk_d;
  logic            i2c_en_q, i2c_en_d;
  logic [DLW-1:0]  delay_cnt_q, delay_cnt_d;
  logic            load_ph_q, load_ph_d;
  logic [7:0]      lut_index_q, lut_index_d;
  logic [23:0]     i2c_wdata_q, i2c_wdata_d;
  logic [RW-1:0]   retry_cnt_q, retry_cnt_d;
  logic            ack_q, ack_d;
  logic            i2c_go_q, i2c_go_d;
  logic            cfg_done_q, cfg_done_d;
  logic            cfg_err_q, cfg_err_d;

  // Strobes are computed from the next count so they line up with div_cnt_q.
  always_comb begin
    div_cnt_d = (div_cnt_q == DCW'(DIV - 1)) ? '0 : div_cnt_q + 1'b1;
    i2c_clk_d = (div_cnt_d >= DCW'(DIV / 2));
    i2c_en_d  = (div_cnt_d == DCW'(DIV / 4));
  end

  always_comb begin
    state_d     = state_q;
    delay_cnt_d = delay_cnt_q;
    load_ph_d   = load_ph_q;
    lut_index_d = lut_index_q;
    i2c_wdata_d = i2c_wdata_q;
    retry_cnt_d = retry_cnt_q;
    ack_d       = ack_q;
    cfg_done_d  = cfg_done_q;
    cfg_err_d   = cfg_err_q;
    case (state_q)
      S_DELAY: begin
        if (delay_cnt_q == DLW'(INIT_DELAY_CYC - 1)) state_d = S_LOAD;
        else delay_cnt_d = delay_cnt_q + 1'b1;
      end
      S_LOAD: begin
        // First cycle lets the LUT settle on the held index; second captures it.
        if (!load_ph_q) begin
          load_ph_d = 1'b1;
        end else begin
          load_ph_d   = 1'b0;
          i2c_wdata_d = {SLAVE_ADDR, lut_data};
          state_d     = S_GO;
        end
      end
      S_GO: begin
        if (i2c_end) begin
          ack_d   = i2c_ack;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!ack_q) begin
          retry_cnt_d = '0;
          state_d     = S_NEXT;
        end else if (retry_cnt_q < RW'(MAX_RETRY)) begin
          retry_cnt_d = retry_cnt_q + 1'b1;
          state_d     = S_GAP;
        end else begin
          cfg_err_d   = 1'b1;
          retry_cnt_d = '0;
          state_d     = S_NEXT;
        end
      end
      S_GAP: begin
        // Controller only clears END once it has seen go low on an enable pulse.
        if (i2c_en_q && !i2c_end) state_d = S_LOAD;
      end
      S_NEXT: begin
        if (lut_index_q == 8'(LUT_SIZE - 1)) begin
          cfg_done_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          lut_index_d = lut_index_q + 1'b1;
          state_d     = S_GAP;
        end
      end
      S_DONE: begin
`ifdef CFG_RESTART_EN
        if (cfg_restart) begin
          cfg_done_d  = 1'b0;
          cfg_err_d   = 1'b0;
          lut_index_d = '0;
          retry_cnt_d = '0;
          state_d     = S_GAP;
        end
`endif
      end
      default: state_d = S_DELAY;
    endcase
    i2c_go_d = (state_d == S_GO);
  end

`ifndef CFG_RESTART_EN
  logic unused_cfg_restart;
  assign unused_cfg_restart = cfg_restart;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= S_DELAY;
      div_cnt_q   <= '0;
      i2c_clk_q   <= 1'b0;
      i2c_en_q    <= 1'b0;
      delay_cnt_q <= '0;
      load_ph_q   <= 1'b0;
      lut_index_q <= '0;
      i2c_wdata_q <= '0;
      retry_cnt_q <= '0;
      ack_q       <= 1'b0;
      i2c_go_q    <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      i2c_clk_q   <= i2c_clk_d;
      i2c_en_q    <= i2c_en_d;
      delay_cnt_q <= delay_cnt_d;
      load_ph_q   <= load_ph_d;
      lut_index_q <= lut_index_d;
      i2c_wdata_q <= i2c_wdata_d;
      retry_cnt_q <= retry_cnt_d;
      ack_q       <= ack_d;
      i2c_go_q    <= i2c_go_d;
      cfg_done_q  <= cfg_done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign i2c_clk   = i2c_clk_q;
  assign i2c_en    = i2c_en_q;
  assign i2c_wdata = i2c_wdata_q;
  assign i2c_wr    = 1'b1;
  assign i2c_go    = i2c_go_q;
  assign lut_index = lut_index_q;
  assign cfg_done  = cfg_done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_i2c_ov7670_config.sv
// Directed bench for i2c_ov7670_config: DIV=8, 16-cycle delay, 3-entry LUT, behavioural SCCB controller with NACK injection.
module tb_i2c_ov7670_config;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        i2c_clk, i2c_en, i2c_wr, i2c_go;
  logic [23:0] i2c_wdata;
  logic        i2c_end, i2c_ack;
  logic [7:0]  lut_index;
  logic [15:0] lut_data;
  logic        cfg_done, cfg_err;
  logic        cfg_restart;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [23:0] attempts[$];
  int          stab_err  = 0;
  int          nack_mode = 0;
  int          nack_used = 0;
  logic        busy = 1'b0;
  int          nen  = 0;
  logic [23:0] cur  = '0;

  i2c_ov7670_config #(
    .CLK_FREQ(8), .I2C_FREQ(1), .LUT_SIZE(3), .INIT_DELAY_CYC(16),
    .SLAVE_ADDR(8'h42), .MAX_RETRY(3)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .i2c_clk(i2c_clk), .i2c_en(i2c_en),
    .i2c_wdata(i2c_wdata), .i2c_wr(i2c_wr), .i2c_go(i2c_go),
    .i2c_end(i2c_end), .i2c_ack(i2c_ack), .lut_index(lut_index),
    .lut_data(lut_data), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .cfg_restart(cfg_restart)
  );

  always #5 iCLK = ~iCLK;

  // Registered LUT: data follows lut_index by one cycle.
  always @(posedge iCLK) begin
    case (lut_index)
      8'd0:    lut_data <= 16'h1280;
      8'd1:    lut_data <= 16'h1100;
      8'd2:    lut_data <= 16'h3A04;
      default: lut_data <= 16'hFFFF;
    endcase
  end

  // Controller model: END after 3 enable pulses, cleared on an enable pulse with go low.
  always @(negedge iCLK) begin
    if (!iRST_N) begin
      busy = 1'b0; i2c_end = 1'b0; i2c_ack = 1'b0; nen = 0;
    end else if (!busy) begin
      if (i2c_go) begin
        busy = 1'b1; nen = 0; cur = i2c_wdata;
        attempts.push_back(i2c_wdata);
      end
    end else if (!i2c_end) begin
      if (i2c_wdata !== cur) stab_err++;
      if (i2c_en) begin
        nen++;
        if (nen == 3) begin
          i2c_end = 1'b1;
          i2c_ack = 1'b0;
          if (nack_mode == 1 && cur[15:8] == 8'h11 && nack_used == 0) begin
            i2c_ack = 1'b1; nack_used = 1;
          end
          if (nack_mode == 2 && cur[15:8] == 8'h12) i2c_ack = 1'b1;
        end
      end
    end else if (i2c_en && !i2c_go) begin
      i2c_end = 1'b0; i2c_ack = 1'b0; busy = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, required finish before 400us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_log(input string tag, input int n, input logic [23:0] e[6]);
    logic [31:0] obs;
    check({tag, "_count"}, attempts.size(), n);
    for (int i = 0; i < n; i++) begin
      obs = (i < attempts.size()) ? {8'h0, attempts[i]} : 32'hDEAD_BEEF;
      check($sformatf("%s_w%0d", tag, i), obs, {8'h0, e[i]});
    end
    check({tag, "_stable"}, stab_err, 0);
  endtask

  task automatic do_reset();
    iRST_N = 1'b0; cfg_restart = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_go",   i2c_go,    0);
    check("rst_clk",  i2c_clk,   0);
    check("rst_en",   i2c_en,    0);
    check("rst_idx",  lut_index, 0);
    check("rst_wdat", i2c_wdata, 0);
    check("rst_done", {cfg_done, cfg_err}, 0);
    check("rst_wr",   i2c_wr,    1);
    attempts.delete(); stab_err = 0; nack_used = 0;
    @(negedge iCLK);
    iRST_N = 1'b1;
  endtask

  // Divider pattern for 16 cycles after release, then go must rise exactly at cycle 18.
  task automatic run_timing(input string tag);
    for (int k = 1; k <= 18; k++) begin
      @(posedge iCLK);
      #1;
      if (k <= 16)
        check($sformatf("%s_div%0d", tag, k), {i2c_en, i2c_clk},
              {((k % 8) == 2), ((k % 8) >= 4)});
      if (k >= 17)
        check($sformatf("%s_go%0d", tag, k), i2c_go, (k == 18));
    end
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && !cfg_done; i++) @(posedge iCLK);
    #1;
    check({tag, "_done"}, cfg_done, 1);
  endtask

  logic [23:0] e_norm[6] = '{24'h421280, 24'h421100, 24'h423A04, 24'h0, 24'h0, 24'h0};
  logic [23:0] e_nack[6] = '{24'h421280, 24'h421100, 24'h421100, 24'h423A04, 24'h0, 24'h0};
  logic [23:0] e_stuck[6] = '{24'h421280, 24'h421280, 24'h421280, 24'h421280, 24'h421100, 24'h423A04};

  initial begin
    int cnt;
    logic seen;

    // T1/T2 divider and normal sequence
    nack_mode = 0;
    do_reset();
    run_timing("t1");
    wait_done("t2", 3000);
    check("t2_err", cfg_err, 0);
    check("t2_idx", lut_index, 2);
    check_log("t2", 3, e_norm);

    // T3 single NACK on entry 1
    nack_mode = 1;
    do_reset();
    wait_done("t3", 3000);
    check("t3_err", cfg_err, 0);
    check_log("t3", 4, e_nack);

    // T4 entry 0 never acknowledged
    nack_mode = 2;
    do_reset();
    wait_done("t4", 4000);
    check("t4_err", cfg_err, 1);
    check_log("t4", 6, e_stuck);

    // Restart pulse while done
    nack_mode = 0;
    attempts.delete(); stab_err = 0;
    @(negedge iCLK); cfg_restart = 1'b1;
    @(negedge iCLK); cfg_restart = 1'b0;
`ifdef CFG_RESTART_EN
    check("t6_done_clr", cfg_done, 0);
    check("t6_err_clr",  cfg_err,  0);
    check("t6_idx_clr",  lut_index, 0);
    seen = 1'b0; cnt = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge iCLK); #1; cnt++;
      seen = i2c_go;
    end
    check("t6_go_fast", (seen && cnt <= 12), 1);
    wait_done("t6", 3000);
    check("t6_err", cfg_err, 0);
    check_log("t6", 3, e_norm);
`else
    repeat (40) @(posedge iCLK);
    #1;
    check("t6_ign_done", cfg_done, 1);
    check("t6_ign_err",  cfg_err,  1);
    check("t6_ign_go",   attempts.size(), 0);
`endif

    // T5 reset while entry 1 is in flight
    nack_mode = 0;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(posedge iCLK);
      seen = (attempts.size() == 2) && i2c_go;
    end
    check("t5_inflight", seen, 1);
    #2 iRST_N = 1'b0;
    #1;
    check("t5_go_async", i2c_go, 0);
    check("t5_idx",      lut_index, 0);
    check("t5_wdat",     i2c_wdata, 0);
    repeat (2) @(negedge iCLK);
    attempts.delete(); stab_err = 0;
    iRST_N = 1'b1;
    run_timing("t5");
    wait_done("t5", 3000);
    check("t5_err", cfg_err, 0);
    check_log("t5", 3, e_norm);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
